// File: rtl/sw_irq_ctrl.sv
// Switch-input interrupt controller: per-switch sync/debounce/edge-capture lanes
// feeding a lowest-index-first request FSM held until the CPU acknowledges.

module sw_irq_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  input  logic clr,
  output logic stable,
  output logic pending
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          accept, rise;

  assign accept = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept && sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // a new rising edge beats a same-cycle ack clear
      pending <= (pending & ~clr) | rise;
    end
  end
endmodule

module sw_irq_ctrl #(
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ID_WIDTH        = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic [SW_WIDTH-1:0] IRQ_MASK,
  input  logic                IRQ_ACK,
  output logic                IRQ,
  output logic [ID_WIDTH-1:0] IRQ_ID,
  output logic [SW_WIDTH-1:0] SW_STABLE,
  output logic [SW_WIDTH-1:0] PENDING
);
  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic [SW_WIDTH-1:0] req, clr;
  logic [ID_WIDTH-1:0] lo_id;

  sw_irq_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [SW_WIDTH-1:0] (
    .clk     (CLK),
    .rst_n   (RST),
    .sw      (SW),
    .clr     (clr),
    .stable  (SW_STABLE),
    .pending (PENDING)
  );

  assign req = PENDING & IRQ_MASK;
  assign clr = (state == REQ && IRQ_ACK) ? (SW_WIDTH'(1) << IRQ_ID) : '0;

  always_comb begin
    lo_id = '0;
    for (int i = SW_WIDTH - 1; i >= 0; i--)
      if (req[i]) lo_id = ID_WIDTH'(i);
  end

  // mask is only consulted on entry to REQ; a masked-off active request stays up
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      IRQ    <= 1'b0;
      IRQ_ID <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          IRQ_ID <= lo_id;
          IRQ    <= 1'b1;
          state  <= REQ;
        end
        REQ: if (IRQ_ACK) begin
          IRQ   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
